mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory between the instruction-fetch path (port 0) and the load/store path (port 1). It accepts one request at a time under round-robin priority, drives the memory for exactly one cycle, and returns a registered response to the winning requester. It sits between the core's memory requesters and the memory block, until the cache replaces it.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that gives the instruction-fetch port (0) and the load/store port (1)
// one-at-a-time access to a single-port memory, with a registered response two cycles after accept.
module mem_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_req0_valid,
  input  logic                  i_req0_we,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  input  logic                  i_req1_valid,
  input  logic                  i_req1_we,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  output logic                  o_req0_ready,
  output logic                  o_req1_ready,
  output logic                  o_rsp0_valid,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_mem_write_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data,
  output logic [1:0]            o_dbg_state
);

  // Handshake: a request transfers on a cycle where valid and ready are both high; the requester
  // holds valid and its fields stable until then. Responses are single-cycle strobes, never stalled.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic window;
  logic accept;
  logic win_port;

  // A new request may be taken while the previous response is on the bus.
  assign window   = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign accept   = window && (i_req0_valid || i_req1_valid);
  assign win_port = (i_req0_valid && i_req1_valid) ? prio_q : i_req1_valid;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = accept ? ST_ACCESS : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req0_ready   = accept && !win_port;
    o_req1_ready   = accept && win_port;
    o_rsp0_valid   = (state_q == ST_RESP) && !port_q;
    o_rsp1_valid   = (state_q == ST_RESP) && port_q;
    o_mem_write_en = (state_q == ST_ACCESS) && we_q;
    o_dbg_state    = state_q;
  end

  assign o_mem_addr       = addr_q;
  assign o_mem_write_data = wdata_q;
  assign o_rsp_rdata      = rdata_q;

  always_comb begin
    prio_d  = prio_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept) begin
      prio_d  = !win_port;
      port_d  = win_port;
      we_d    = win_port ? i_req1_we    : i_req0_we;
      addr_d  = win_port ? i_req1_addr  : i_req0_addr;
      wdata_d = win_port ? i_req1_wdata : i_req0_wdata;
    end
    // Captured in the same cycle as a write, so a write returns the old contents.
    if (state_q == ST_ACCESS) rdata_d = i_mem_read_data;
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      prio_q  <= 1'b0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      prio_q  <= prio_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random two-port traffic, checked against a
// reference memory and a round-robin grant model in a negedge monitor.
module tb_mem_arbiter;

  localparam int DW = 64;
  localparam int AW = 10;

  logic          i_clk = 1'b0;
  logic          i_arst = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_we = 2'b00;
  logic [AW-1:0] req_addr [2];
  logic [DW-1:0] req_wdata [2];
  logic          o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid;
  logic [DW-1:0] o_rsp_rdata, o_mem_write_data, i_mem_read_data;
  logic          o_mem_write_en;
  logic [AW-1:0] o_mem_addr;
  logic [1:0]    o_dbg_state;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ref_mem [1024];
  logic          mem_ready = 1'b0;

  logic [DW-1:0] exp_q [$];
  bit            exp_port_q [$];
  int            exp_cyc_q [$];
  bit            grant_log [$];
  int            grant_cyc_log [$];

  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  acc_cyc = -10;
  bit  acc_we = 1'b0;
  logic [AW-1:0] acc_addr = '0;
  logic [DW-1:0] acc_wdata = '0;
  bit  model_prio = 1'b0;
  bit  mon_en = 1'b0;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk            (i_clk),
    .i_arst           (i_arst),
    .i_req0_valid     (req_valid[0]),
    .i_req0_we        (req_we[0]),
    .i_req0_addr      (req_addr[0]),
    .i_req0_wdata     (req_wdata[0]),
    .i_req1_valid     (req_valid[1]),
    .i_req1_we        (req_we[1]),
    .i_req1_addr      (req_addr[1]),
    .i_req1_wdata     (req_wdata[1]),
    .o_req0_ready     (o_req0_ready),
    .o_req1_ready     (o_req1_ready),
    .o_rsp0_valid     (o_rsp0_valid),
    .o_rsp1_valid     (o_rsp1_valid),
    .o_rsp_rdata      (o_rsp_rdata),
    .o_mem_write_en   (o_mem_write_en),
    .o_mem_addr       (o_mem_addr),
    .o_mem_write_data (o_mem_write_data),
    .i_mem_read_data  (i_mem_read_data),
    .o_dbg_state      (o_dbg_state)
  );

  // ---------------- clock / reset / memory ----------------
  always #5 i_clk = ~i_clk;

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 'h010) return 64'hDEADBEEF_00000001;
    if (a == 'h020) return 64'h0;
    if (a == 'h030) return 64'h5555_AAAA_0000_0030;
    return {32'hC0DE0000 | 32'(a), 32'(a) * 32'h9E3779B1};
  endfunction

  assign i_mem_read_data = mem[o_mem_addr];

  always @(posedge i_clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (o_mem_write_en) begin
      mem[o_mem_addr] <= o_mem_write_data;
    end
  end

  function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic do_reset();
    i_arst = 1'b1;
    repeat (2) @(posedge i_clk);
    #2 i_arst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {o_req1_ready, o_req0_ready}, 2'b00);
    check({tag, "_rsp"}, {o_rsp1_valid, o_rsp0_valid}, 2'b00);
    check({tag, "_rdata"}, o_rsp_rdata, 0);
    check({tag, "_we"}, o_mem_write_en, 0);
    check({tag, "_addr"}, o_mem_addr, 0);
    check({tag, "_wdata"}, o_mem_write_data, 0);
  endtask

  // ---------------- driver ----------------
  task automatic issue(input int p, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int  n;
    logic rdy;
    req_we[p] = we;
    req_addr[p] = addr;
    req_wdata[p] = wd;
    req_valid[p] = 1'b1;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
      rdy = (p == 0) ? o_req0_ready : o_req1_ready;
    end while (!rdy && n < 64);
    if (!rdy) check($sformatf("accept_timeout_p%0d", p), rdy, 1'b1);
    @(posedge i_clk);
    #1 req_valid[p] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 32) begin
      @(negedge i_clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge i_clk) begin
    logic [1:0] exp_rsp, exp_rdy;
    bit         exp_wen, w;
    logic [DW-1:0] d;
    if (i_arst || !mon_en) begin
      exp_q.delete();
      exp_port_q.delete();
      exp_cyc_q.delete();
      acc_cyc = -10;
      acc_we = 1'b0;
      model_prio = 1'b0;
    end else begin
      cyc++;
      exp_rsp = 2'b00;
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) exp_rsp = exp_port_q[0] ? 2'b10 : 2'b01;
      check("rsp_valid", {o_rsp1_valid, o_rsp0_valid}, exp_rsp);
      if (exp_rsp != 2'b00) begin
        check("rsp_rdata", o_rsp_rdata, exp_q[0]);
        void'(exp_q.pop_front());
        void'(exp_port_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end

      exp_wen = (cyc == acc_cyc + 1) && acc_we;
      check("mem_write_en", o_mem_write_en, exp_wen);
      if (cyc == acc_cyc + 1) begin
        check("mem_addr", o_mem_addr, acc_addr);
        if (acc_we) check("mem_wdata", o_mem_write_data, acc_wdata);
      end

      // Round-robin model: a grant is possible whenever the previous cycle was not an accept.
      exp_rdy = 2'b00;
      w = (req_valid == 2'b11) ? model_prio : req_valid[1];
      if ((cyc != acc_cyc + 1) && (req_valid != 2'b00)) exp_rdy[w] = 1'b1;
      check("req_ready", {o_req1_ready, o_req0_ready}, exp_rdy);
      if (exp_rdy != 2'b00) begin
        d = ref_mem[req_addr[w]];
        if (req_we[w]) ref_mem[req_addr[w]] = req_wdata[w];
        exp_q.push_back(d);
        exp_port_q.push_back(w);
        exp_cyc_q.push_back(cyc + 2);
        grant_log.push_back(w);
        grant_cyc_log.push_back(cyc);
        acc_cyc = cyc;
        acc_we = req_we[w];
        acc_addr = req_addr[w];
        acc_wdata = req_wdata[w];
        model_prio = !w;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    req_addr[0] = '0; req_addr[1] = '0;
    req_wdata[0] = '0; req_wdata[1] = '0;
    do_reset();
    check_reset_outputs("reset");
    mon_en = 1'b1;
    @(posedge i_clk);
    #1;

    // single read on port 0
    issue(0, 1'b0, 10'h010, 64'h0);
    drain();

    // write then read on port 1, read accepted during the write's response cycle
    issue(1, 1'b1, 10'h020, 64'h1234_5678_9ABC_DEF0);
    issue(1, 1'b0, 10'h020, 64'h0);
    drain();

    // contention from reset: both ports continuously valid
    do_reset();
    @(posedge i_clk);
    #1;
    grant_log.delete();
    grant_cyc_log.delete();
    fork
      for (int k = 0; k < 4; k++) issue(0, 1'b0, AW'($urandom_range(0, 1023)), 64'h0);
      for (int k = 0; k < 4; k++) issue(1, 1'b0, AW'($urandom_range(0, 1023)), 64'h0);
    join
    drain();
    check("contention_grants", grant_log.size(), 8);
    for (int k = 0; k < grant_log.size() && k < 8; k++) begin
      check($sformatf("contention_port_%0d", k), grant_log[k], k % 2);
      if (k > 0) check($sformatf("contention_gap_%0d", k), grant_cyc_log[k] - grant_cyc_log[k-1], 2);
    end

    // fairness after idle: port 1 alone, then both together
    repeat (3) @(posedge i_clk);
    #1;
    grant_log.delete();
    issue(1, 1'b0, 10'h011, 64'h0);
    drain();
    fork
      issue(0, 1'b0, 10'h012, 64'h0);
      issue(1, 1'b0, 10'h013, 64'h0);
    join
    drain();
    check("fair_count", grant_log.size(), 3);
    if (grant_log.size() >= 3) begin
      check("fair_first", grant_log[1], 1'b0);
      check("fair_second", grant_log[2], 1'b1);
    end

    // reset in the middle of a port-0 write
    issue(0, 1'b1, 10'h030, 64'hFFFF_0000_FFFF_0000);
    check("pre_reset_we", o_mem_write_en, 1'b1);
    #1 i_arst = 1'b1;
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge i_clk);
    check("midreset_held_we", o_mem_write_en, 1'b0);
    #2 i_arst = 1'b0;
    ref_mem[10'h030] = init_word('h030);
    check("midreset_mem", mem[10'h030], 64'h5555_AAAA_0000_0030);
    check_reset_outputs("postreset");
    @(posedge i_clk);
    #1;
    issue(0, 1'b0, 10'h030, 64'h0);
    drain();

    // random traffic with address overlap between ports
    fork
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge i_clk);
        #1 issue(0, 1'($urandom_range(0, 1)), AW'(10'h040 + $urandom_range(0, 7)), {$urandom, $urandom});
      end
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge i_clk);
        #1 issue(1, 1'($urandom_range(0, 1)), AW'(10'h040 + $urandom_range(0, 7)), {$urandom, $urandom});
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
